ex_stage: RTL

Execute stage of the 5-stage pipelined CPU, directly downstream of the ID/EX pipeline register. It decodes the 4-bit EX control field and funct, and computes the ALU result and destination register combinationally. An iterative 32-cycle shift-add unit executes MULTU into HI/LO. While that unit runs, the block drives `busy`, which the hazard logic feeds back as the ID/EX `mul` hold so the instruction registers stay frozen until the product is written.

---
 rtl/ex_pkg.sv | 44 ++++
 rtl/ex_stage_if.sv | 36 +++
 rtl/ex_stage_mul_iter.sv | 110 +++++++++++
 rtl/ex_stage.sv | 91 +++++++++
 4 files changed

// File: rtl/ex_pkg.sv
`default_nettype none
// ============================================================================
// Package  : ex_pkg
// Desc     : Shared encodings for the execute stage: ALUOp codes, R-type
//            funct codes and the iterative multiplier state type.
// Rev      : 1.0 - initial release
// ============================================================================
package ex_pkg;

  // ALUOp field, ex_ctrl[1:0]
  localparam logic [1:0] c_aluop_add   = 2'b00;
  localparam logic [1:0] c_aluop_sub   = 2'b01;
  localparam logic [1:0] c_aluop_rtype = 2'b10;
  localparam logic [1:0] c_aluop_slt   = 2'b11;

  // R-type funct codes
  localparam logic [5:0] c_funct_sll   = 6'h00;
  localparam logic [5:0] c_funct_srl   = 6'h02;
  localparam logic [5:0] c_funct_mfhi  = 6'h10;
  localparam logic [5:0] c_funct_mflo  = 6'h12;
  localparam logic [5:0] c_funct_mult  = 6'h18;
  localparam logic [5:0] c_funct_multu = 6'h19;
  localparam logic [5:0] c_funct_add   = 6'h20;
  localparam logic [5:0] c_funct_sub   = 6'h22;
  localparam logic [5:0] c_funct_and   = 6'h24;
  localparam logic [5:0] c_funct_or    = 6'h25;
  localparam logic [5:0] c_funct_slt   = 6'h2A;

  // Iterative multiplier states
  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

  // True when the control/funct pair names the given multiply opcode
  function automatic logic is_rtype_funct(input logic [1:0] aluop,
                                          input logic [5:0] funct,
                                          input logic [5:0] code);
    return (aluop == c_aluop_rtype) && (funct == code);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_stage_if.sv
`default_nettype none
// ============================================================================
// Interface: ex_stage_if
// Desc     : ID/EX operand bundle into the execute stage and its results.
//            master = ID/EX side driving operands, slave = execute stage.
// Rev      : 1.0 - initial release
// ============================================================================
interface ex_stage_if #(
  parameter int WIDTH = 32
);
  logic [3:0]       ex_ctrl;
  logic [5:0]       funct;
  logic [4:0]       shamt;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic [WIDTH-1:0] immed;
  logic [4:0]       rt;
  logic [4:0]       rd;
  logic [WIDTH-1:0] alu_result;
  logic             zero;
  logic [4:0]       wr_reg;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output ex_ctrl, funct, shamt, rd1, rd2, immed, rt, rd,
    input  alu_result, zero, wr_reg, busy, hi, lo
  );

  modport slave (
    input  ex_ctrl, funct, shamt, rd1, rd2, immed, rt, rd,
    output alu_result, zero, wr_reg, busy, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/ex_stage_mul_iter.sv
`default_nettype none
// ============================================================================
// Module   : mul_iter
// Desc     : WIDTH-cycle shift-add multiplier writing HI/LO. Works on operand
//            magnitudes; signed_op negates the product on completion when the
//            operand signs differ.
// Rev      : 1.0 - initial release
// ============================================================================
module mul_iter
  import ex_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_op,
  output logic             busy_run,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]        c_last      = CW'(WIDTH - 1);
  localparam logic [CW-1:0]        c_count_one = CW'(1);
  localparam logic [WIDTH-1:0]     c_one       = WIDTH'(1);
  localparam logic [2*WIDTH-1:0]   c_one_2w    = (2*WIDTH)'(1);

  mul_state_t         r_state;
  logic [CW-1:0]      r_count;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_prod;
  logic               r_neg;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod_next;
  logic [2*WIDTH-1:0] w_final;
  logic               w_unused_prod_lsb;

  // The product LSB is shifted out every step and never read back
  assign w_unused_prod_lsb = r_prod[0];

  // Operand magnitudes and one shift-add step of the product
  always_comb begin
    w_abs_a = a;
    w_abs_b = b;
    if (signed_op && a[WIDTH-1]) w_abs_a = ~a + c_one;
    if (signed_op && b[WIDTH-1]) w_abs_b = ~b + c_one;
    w_sum = {1'b0, r_prod[2*WIDTH-1:WIDTH]}
          + (r_mplier[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    // {carry, upper, lower} shifted right by one drops the old LSB
    w_prod_next = {w_sum, r_prod[WIDTH-1:1]};
    w_final     = r_neg ? (~w_prod_next + c_one_2w) : w_prod_next;
  end

  // Hold upstream from the launch cycle through the last iteration
  assign busy_run = ((r_state == MUL_IDLE) && start) || (r_state == MUL_RUN);
  assign hi       = r_hi;
  assign lo       = r_lo;

  // Multiplier FSM: launch, iterate WIDTH times, one DONE cycle to absorb the held opcode
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= MUL_IDLE;
      r_count  <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_neg    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        MUL_IDLE: begin
          if (start) begin
            r_mcand  <= w_abs_a;
            r_mplier <= w_abs_b;
            r_prod   <= '0;
            r_count  <= '0;
            r_neg    <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_state  <= MUL_RUN;
          end
        end
        MUL_RUN: begin
          r_prod   <= w_prod_next;
          r_mplier <= r_mplier >> 1;
          if (r_count == c_last) begin
            r_prod  <= w_final;
            r_hi    <= w_final[2*WIDTH-1:WIDTH];
            r_lo    <= w_final[WIDTH-1:0];
            r_state <= MUL_DONE;
          end else begin
            r_count <= r_count + c_count_one;
          end
        end
        MUL_DONE: r_state <= MUL_IDLE;
        default:  r_state <= MUL_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage
// Desc     : Pipeline execute stage: combinational ALU, operand-B and
//            destination muxes, plus the iterative HI/LO multiplier.
// Config   : MUL_SIGNED_EN - when defined, funct 0x18 (MULT) also launches
//            the multiplier as a signed multiply.
// Rev      : 1.0 - initial release
// ============================================================================
module ex_stage
  import ex_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  ex_stage_if.slave bus
);

  logic [1:0]       w_aluop;
  logic             w_alu_src;
  logic             w_reg_dst;
  logic [WIDTH-1:0] w_op_b;
  logic             w_is_multu;
  logic             w_is_mult;
  logic             w_slt;
  logic [WIDTH-1:0] w_result;
  logic             w_busy;
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;

  assign w_aluop    = bus.ex_ctrl[1:0];
  assign w_alu_src  = bus.ex_ctrl[2];
  assign w_reg_dst  = bus.ex_ctrl[3];
  assign w_op_b     = w_alu_src ? bus.immed : bus.rd2;
  assign w_is_multu = is_rtype_funct(w_aluop, bus.funct, c_funct_multu);
`ifdef MUL_SIGNED_EN
  assign w_is_mult  = is_rtype_funct(w_aluop, bus.funct, c_funct_mult);
`else
  assign w_is_mult  = 1'b0;
`endif
  assign w_slt      = $signed(bus.rd1) < $signed(w_op_b);

  // ALU: ALUOp selects the operation, R-type further decoded by funct
  always_comb begin
    w_result = '0;
    case (w_aluop)
      c_aluop_add: w_result = bus.rd1 + w_op_b;
      c_aluop_sub: w_result = bus.rd1 - w_op_b;
      c_aluop_slt: w_result = {{(WIDTH-1){1'b0}}, w_slt};
      default: begin
        case (bus.funct)
          c_funct_add:   w_result = bus.rd1 + w_op_b;
          c_funct_sub:   w_result = bus.rd1 - w_op_b;
          c_funct_and:   w_result = bus.rd1 & w_op_b;
          c_funct_or:    w_result = bus.rd1 | w_op_b;
          c_funct_slt:   w_result = {{(WIDTH-1){1'b0}}, w_slt};
          c_funct_sll:   w_result = bus.rd2 << bus.shamt;
          c_funct_srl:   w_result = bus.rd2 >> bus.shamt;
          c_funct_mfhi:  w_result = w_hi;
          c_funct_mflo:  w_result = w_lo;
          c_funct_multu: w_result = '0;
          default:       w_result = '0;
        endcase
      end
    endcase
  end

  mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul_iter (
    .clk       (clk),
    .rst       (rst),
    .start     (w_is_multu | w_is_mult),
    .a         (bus.rd1),
    .b         (bus.rd2),
    .signed_op (w_is_mult),
    .busy_run  (w_busy),
    .hi        (w_hi),
    .lo        (w_lo)
  );

  assign bus.alu_result = w_result;
  assign bus.zero       = (w_result == '0);
  assign bus.wr_reg     = w_reg_dst ? bus.rd : bus.rt;
  assign bus.busy       = w_busy;
  assign bus.hi         = w_hi;
  assign bus.lo         = w_lo;

endmodule
`default_nettype wire
